// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first. Optional signed overflow under SERIAL_ADDER_OVF_EN.
// Latency: done pulses WIDTH+1 cycles after the start edge. A new add can start every WIDTH+2 cycles.
// Backpressure: none. start is taken only in IDLE and dropped in SHIFT or DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_next;
  logic             last;
  logic [WIDTH:0]   sum_cat;

  assign s_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next  = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign last    = (cnt == CW'(WIDTH - 1));
  // The new bit enters at the MSB. Widening first keeps WIDTH=1 legal.
  assign sum_cat = {s_bit, sum};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          carry <= c_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum   <= sum_cat[WIDTH:1];
          if (last) begin
            cout  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf   <= carry ^ c_next;
`endif
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder with WIDTH=8. It uses a vector table, hand-built timing sequences and random adds.
// The random adds are checked against plain integer addition.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic logic cur_ovf();
`ifdef SERIAL_ADDER_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Must be called just after a negedge while the DUT is idle.
  // The task returns just after a negedge, with the DUT back in IDLE.
  task automatic do_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output logic [7:0] rs, output logic rc, output logic ro,
                        output int lat, output int nbusy);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    rs = sum;
    rc = cout;
    ro = cur_ovf();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc;
    logic       ro;
    int         lat;
    int         nbusy;
    int         ndone;
    int         last_done;
    logic [8:0] ref_r;
    logic       ref_o;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rci;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    tbl[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_add(tbl[i].a, tbl[i].b, tbl[i].cin, rs, rc, ro, lat, nbusy);
      check($sformatf("tbl%0d sum", i), rs, tbl[i].s);
      check($sformatf("tbl%0d cout", i), rc, tbl[i].c);
      check($sformatf("tbl%0d latency", i), lat, 9);
      check($sformatf("tbl%0d busy cycles", i), nbusy, 8);
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("tbl%0d ovf", i), ro, tbl[i].o);
`endif
    end

    // Pulses of start during SHIFT and during DONE must both be dropped.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    ndone = 0; rs = '0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = 8'hAA;
      if (done) begin
        ndone++;
        rs = sum;
        start = (ndone == 1);
      end
      if (cyc == 3) start = 1'b1;
    end
    check("ignore start done count", ndone, 1);
    check("ignore start sum", rs, 8'h46);
    check("ignore start idle after", busy, 0);

    // An abort in the 4th SHIFT cycle must clear everything and must not produce a done pulse.
    do_add(8'hFF, 8'h01, 1'b0, rs, rc, ro, lat, nbusy);
    a = 8'h55; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);
    do_add(8'h01, 8'h02, 1'b0, rs, rc, ro, lat, nbusy);
    check("after abort sum", rs, 8'h03);
    check("after abort cout", rc, 0);

    // With start held high, adds run back to back with done pulses 10 cycles apart.
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    ndone = 0; last_done = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("held sum", sum, 8'h00);
        check("held cout", cout, 1);
        check("held spacing", cyc - last_done, (ndone == 1) ? 9 : 10);
        last_done = cyc;
      end
    end
    start = 1'b0;
    check("held done count", ndone, 4);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom_range(0, 1));
      ref_r = 9'(ra) + 9'(rb) + 9'(rci);
      ref_o = (ra[7] == rb[7]) && (ref_r[7] != ra[7]);
      do_add(ra, rb, rci, rs, rc, ro, lat, nbusy);
      check($sformatf("rand%0d result", i), {rc, rs}, ref_r);
      check($sformatf("rand%0d latency", i), lat, 9);
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("rand%0d ovf", i), ro, ref_o);
`else
      if (ro !== 1'b0) check($sformatf("rand%0d ovf stub", i), ro, 0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
